// File: rtl/forwarding_pkg.sv
// forwarding_pkg: default parameters and the register-zero constant shared by the forwarding blocks
package forwarding_pkg;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_NUM_READ   = 2;
    localparam int DEF_CNT_WIDTH  = 16;
    // Integer register 0 is hard-wired to zero and never forwarded or reserved
    localparam int REG_ZERO       = 0;
endpackage

// File: rtl/forwarding_select.sv
// forwarding_select: one read port's priority mux over all write-back channels (highest index wins)
// Ports: write_* channel buses, rd_addr/rd_float/rd_data for this read, fwd_data result, hit when any channel matched
module forwarding_select
    import forwarding_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]            write_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]      write_data,
    input  logic [NUM_PORTS-1:0]            write_float,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic                            rd_float,
    input  logic [WIDTH-1:0]                rd_data,
    output logic [WIDTH-1:0]                fwd_data,
    output logic                            hit
);
    logic w_zero;
    assign w_zero = !rd_float && rd_addr == ADDR_WIDTH'(REG_ZERO);
    // Ascending scan: a later (higher-index) match overrides earlier ones
    always_comb begin
        fwd_data = rd_data;
        hit      = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (write_enable[p] && write_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr && write_float[p] == rd_float && !w_zero) begin
                fwd_data = write_data[p*WIDTH +: WIDTH];
                hit      = 1'b1;
            end
    end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: write-back forwarding plus int/float pending scoreboard for decode
// Ports: clk/rst_n (async active-low), flush; issue_* reservation request with issue_ready;
// write_* per-channel write-back; read_* per-port sources; forward_data/read_stall per port;
// pending_count (popcount of pending bits) and stall_cycles (saturating stall counter)
module forwarding_scoreboard
    import forwarding_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int NUM_READ   = DEF_NUM_READ,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            issue_valid,
    input  logic [ADDR_WIDTH-1:0]           issue_addr,
    input  logic                            issue_float,
    output logic                            issue_ready,
    input  logic [NUM_PORTS-1:0]            write_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] write_addr,
    input  logic [NUM_PORTS*WIDTH-1:0]      write_data,
    input  logic [NUM_PORTS-1:0]            write_float,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  read_addr,
    input  logic [NUM_READ-1:0]             read_float,
    input  logic [NUM_READ*WIDTH-1:0]       read_data,
    output logic [NUM_READ*WIDTH-1:0]       forward_data,
    output logic [NUM_READ-1:0]             read_stall,
    output logic [ADDR_WIDTH+1:0]           pending_count,
    output logic [CNT_WIDTH-1:0]            stall_cycles
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int PCW  = ADDR_WIDTH + 2;
    logic [NREG-1:0]     r_pend_int, r_pend_float;
    logic [NREG-1:0]     w_clr_int, w_clr_float, w_set_int, w_set_float;
    logic [NREG-1:0]     w_next_int, w_next_float;
    logic [NUM_READ-1:0] w_hit;
    logic                w_issue_acc;
    assign issue_ready = issue_float ? !r_pend_float[issue_addr] : !r_pend_int[issue_addr];
    assign w_issue_acc = issue_valid && issue_ready;
    always_comb begin
        w_clr_int   = '0;
        w_clr_float = '0;
        w_set_int   = '0;
        w_set_float = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (write_enable[p]) begin
                if (write_float[p]) w_clr_float[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
                else                w_clr_int[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]   = 1'b1;
            end
        if (w_issue_acc) begin
            if (issue_float) w_set_float[issue_addr] = 1'b1;
            else             w_set_int[issue_addr]   = 1'b1;
        end
    end
    // Set is applied after clear so a same-cycle issue wins; bit 0 of the int space is forced clear
    assign w_next_int   = flush ? '0 : ((r_pend_int & ~w_clr_int) | w_set_int) & ~NREG'(1);
    assign w_next_float = flush ? '0 : (r_pend_float & ~w_clr_float) | w_set_float;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_pend_int    <= '0;
            r_pend_float  <= '0;
            pending_count <= '0;
            stall_cycles  <= '0;
        end else begin
            r_pend_int    <= w_next_int;
            r_pend_float  <= w_next_float;
            pending_count <= PCW'($countones(w_next_int) + $countones(w_next_float));
            if (|read_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    for (genvar r = 0; r < NUM_READ; r++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_ra;
        assign w_ra = read_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        forwarding_select #(
            .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUM_PORTS(NUM_PORTS)
        ) u_sel (
            .write_enable(write_enable),
            .write_addr  (write_addr),
            .write_data  (write_data),
            .write_float (write_float),
            .rd_addr     (w_ra),
            .rd_float    (read_float[r]),
            .rd_data     (read_data[r*WIDTH +: WIDTH]),
            .fwd_data    (forward_data[r*WIDTH +: WIDTH]),
            .hit         (w_hit[r])
        );
        assign read_stall[r] = (read_float[r] ? r_pend_float[w_ra] : r_pend_int[w_ra]) && !w_hit[r];
    end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: directed and random checks of forwarding_scoreboard against a behavioural model
module tb_forwarding_scoreboard;
    localparam int W = 32, A = 5, NP = 4, NR = 2;
    logic            clk = 1'b0, rst_n = 1'b0, flush, issue_valid, issue_float;
    logic [A-1:0]    issue_addr;
    logic [NP-1:0]   write_enable, write_float;
    logic [NP*A-1:0] write_addr;
    logic [NP*W-1:0] write_data;
    logic [NR*A-1:0] read_addr;
    logic [NR-1:0]   read_float;
    logic [NR*W-1:0] read_data;
    logic [NR*W-1:0] forward_data, fd4;
    logic [NR-1:0]   read_stall, rs4;
    logic            issue_ready, ir4;
    logic [A+1:0]    pending_count, pc4;
    logic [15:0]     stall_cycles;
    logic [3:0]      sc4;
    int checks = 0, errors = 0;
    bit pi[32], pf[32];
    int sc;
    logic exp_ready, any_stall;

    always #5 clk = ~clk;

    forwarding_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_float(issue_float), .issue_ready(issue_ready), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .write_float(write_float),
        .read_addr(read_addr), .read_float(read_float), .read_data(read_data),
        .forward_data(forward_data), .read_stall(read_stall), .pending_count(pending_count),
        .stall_cycles(stall_cycles)
    );
    forwarding_scoreboard #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .issue_valid(issue_valid), .issue_addr(issue_addr),
        .issue_float(issue_float), .issue_ready(ir4), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .write_float(write_float),
        .read_addr(read_addr), .read_float(read_float), .read_data(read_data),
        .forward_data(fd4), .read_stall(rs4), .pending_count(pc4), .stall_cycles(sc4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_addr = 0; issue_float = 0;
        write_enable = 0; write_addr = 0; write_data = 0; write_float = 0;
        read_addr = 0; read_float = 0; read_data = 0;
    endtask

    task automatic set_wr(input int p, input logic [A-1:0] a, input logic [W-1:0] d, input logic f);
        write_enable[p] = 1'b1; write_addr[p*A +: A] = a; write_data[p*W +: W] = d; write_float[p] = f;
    endtask

    task automatic set_rd(input int r, input logic [A-1:0] a, input logic f, input logic [W-1:0] d);
        read_addr[r*A +: A] = a; read_float[r] = f; read_data[r*W +: W] = d;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += pi[i] + pf[i];
        return n;
    endfunction

    task automatic check_comb();
        #1;
        exp_ready = (!issue_float && issue_addr == 0) ? 1'b1 : (issue_float ? !pf[issue_addr] : !pi[issue_addr]);
        chk("issue_ready", issue_ready, exp_ready);
        any_stall = 0;
        for (int r = 0; r < NR; r++) begin
            logic [A-1:0] a = read_addr[r*A +: A];
            logic f = read_float[r];
            logic [W-1:0] d = read_data[r*W +: W];
            logic hit = 0, st;
            for (int p = NP - 1; p >= 0 && !hit; p--)
                if (write_enable[p] && write_addr[p*A +: A] == a && write_float[p] == f && !(!f && a == 0)) begin
                    hit = 1; d = write_data[p*W +: W];
                end
            st = (f ? pf[a] : pi[a]) && !hit;
            any_stall |= st;
            chk($sformatf("forward_data[%0d]", r), forward_data[r*W +: W], d);
            chk($sformatf("read_stall[%0d]", r), read_stall[r], st);
            chk($sformatf("forward4[%0d]", r), fd4[r*W +: W], d);
        end
    endtask

    task automatic tick();
        check_comb();
        @(posedge clk);
        if (flush) begin
            pi = '{default: 0}; pf = '{default: 0};
        end else begin
            for (int p = 0; p < NP; p++)
                if (write_enable[p]) begin
                    if (write_float[p]) pf[write_addr[p*A +: A]] = 0;
                    else pi[write_addr[p*A +: A]] = 0;
                end
            if (issue_valid && exp_ready && !(!issue_float && issue_addr == 0)) begin
                if (issue_float) pf[issue_addr] = 1;
                else pi[issue_addr] = 1;
            end
        end
        if (any_stall) sc++;
        #1;
        chk("pending_count", pending_count, model_count());
        chk("stall_cycles", stall_cycles, sc > 65535 ? 65535 : sc);
        chk("stall_cycles4", sc4, sc > 15 ? 15 : sc);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        pi = '{default: 0}; pf = '{default: 0}; sc = 0;
        chk("rst_pending", pending_count, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_stall_cycles4", sc4, 0);
        chk("rst_read_stall", read_stall, 0);
        chk("rst_issue_ready", issue_ready, 1);
        #1 rst_n = 1;
    endtask

    initial begin
        idle();
        @(posedge clk);
        do_reset();
        // RAW stall then forward on channel 1
        issue_valid = 1; issue_addr = 5; tick();
        idle(); set_rd(0, 5, 0, 32'h99); issue_addr = 5;
        #1;
        chk("r5_stall", read_stall[0], 1);
        chk("r5_issue_blocked", issue_ready, 0);
        chk("r5_pending", pending_count, 1);
        tick();
        set_wr(1, 5, 32'h1234, 0);
        #1;
        chk("r5_forward", forward_data[W-1:0], 32'h1234);
        chk("r5_unstall", read_stall[0], 0);
        tick();
        chk("r5_cleared", pending_count, 0);
        // Multi-channel priority and float-space isolation
        idle(); set_wr(0, 7, 32'hA, 0); set_wr(2, 7, 32'hB, 0); set_wr(3, 7, 32'hC, 0);
        set_rd(0, 7, 0, 32'h0); set_rd(1, 7, 1, 32'h55);
        #1;
        chk("r7_priority", forward_data[W-1:0], 32'hC);
        chk("r7_float_miss", forward_data[2*W-1:W], 32'h55);
        tick();
        // Integer register 0 never forwards nor reserves
        idle(); set_wr(3, 0, 32'hFFFF, 0); set_rd(0, 0, 0, 32'h0);
        issue_valid = 1; issue_addr = 0;
        #1;
        chk("r0_forward", forward_data[W-1:0], 0);
        chk("r0_ready", issue_ready, 1);
        tick();
        chk("r0_pending", pending_count, 0);
        // Issue beats same-cycle write; flush beats issue
        idle(); issue_valid = 1; issue_addr = 3; issue_float = 1; set_wr(0, 3, 32'h7, 1);
        tick();
        chk("f3_issue_wins", pending_count, 1);
        idle(); flush = 1; issue_valid = 1; issue_addr = 4;
        tick();
        chk("flush_wins", pending_count, 0);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            flush = ($urandom_range(0, 19) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_addr = A'($urandom_range(0, 7));
            issue_float = $urandom_range(0, 1);
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 2) == 0) set_wr(p, A'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
            for (int r = 0; r < NR; r++) set_rd(r, A'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
            tick();
        end
        // Stall count of 5, then async reset mid-stall
        idle(); do_reset();
        issue_valid = 1; issue_addr = 9; tick();
        idle(); set_rd(1, 9, 0, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_5", stall_cycles, 5);
        #2 do_reset();
        // Saturation of the 4-bit counter
        idle(); issue_valid = 1; issue_addr = 9; tick();
        idle(); set_rd(1, 9, 0, 32'h1);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt4", sc4, 15);
        chk("cnt16_20", stall_cycles, 20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
